// File: rtl/aes_sched_pkg.sv
// Shared constants for the AES-128 round scheduler: state encoding, round count,
// round-constant endpoints, requester IDs and the rcon step helpers.
package aes_sched_pkg;

  localparam int NR = 10;

  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  localparam logic ID_ENC = 1'b0;
  localparam logic ID_DEC = 1'b1;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_GRANT   = 5'd1,
    ST_PREPASS = 5'd2,
    ST_LOAD    = 5'd3,
    ST_ROUND   = 5'd4,
    ST_FINAL   = 5'd5,
    ST_DONE    = 5'd6
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Undo xtime: an odd value can only have come from a reduction by 0x1B.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? ({1'b0, b[7:1]} ^ 8'h8D) : {1'b0, b[7:1]};
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: loads 0x01 or 0x36, steps forward (xtime) or backward.
module aes_rcon_gen
  import aes_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_first,
  input  logic       ld_last,
  input  logic       step_fwd,
  input  logic       step_inv,
  output logic [7:0] rcon
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcon <= RCON_FIRST;
    end else if (ld_first) begin
      rcon <= RCON_FIRST;
    end else if (ld_last) begin
      rcon <= RCON_LAST;
    end else if (step_fwd) begin
      rcon <= xtime(rcon);
    end else if (step_inv) begin
      rcon <= inv_xtime(rcon);
    end
  end

endmodule

// File: rtl/aes_round_sched.sv
// Scheduler for a shared AES-128 round datapath serving ENC and DEC requesters.
// Optional key cache (skip DEC pre-pass on repeated key): AES_ROUND_SCHED_KEYCACHE_EN.
//
// state   | meaning
// IDLE    | arbitrate; grant is combinational in this cycle
// GRANT   | datapath latches data_in/key_in
// PREPASS | DEC only: forward key expansion up to round key 10
// LOAD    | initial AddRoundKey
// ROUND   | rounds 1..NR-1
// FINAL   | last round, no (Inv)MixColumns
// DONE    | result valid, done pulse
module aes_round_sched
  import aes_sched_pkg::*;
#(
  parameter int PREPASS_CYC = 10
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_enc,
  input  logic       req_dec,
`ifdef AES_ROUND_SCHED_KEYCACHE_EN
  input  logic       key_same,
`endif
  output logic       gnt_enc,
  output logic       gnt_dec,
  output logic       busy,
  output logic       dp_mode,
  output logic       dp_load,
  output logic       dp_round,
  output logic       dp_last,
  output logic       key_step,
  output logic       key_dir,
  output logic [7:0] rcon,
  output logic [3:0] round_idx,
  output logic       done,
  output logic       done_id,
  output logic [4:0] test_state
);

  state_t     state, state_nxt;
  logic       rr_ptr;
  logic       job_id;
  logic       job_dec;
  logic [3:0] cnt;
  logic       skip_pre;
  logic       arb_go;
  logic       pick_dec;
  logic       rc_ld_first, rc_ld_last, rc_fwd, rc_inv;

  assign job_dec  = (job_id == ID_DEC);
  assign pick_dec = req_dec & (~req_enc | rr_ptr);
  // Gated by reset so no grant leaks out while reset is held with a request pending.
  assign arb_go   = reset & (state == ST_IDLE) & (req_enc | req_dec);
  assign gnt_enc  = arb_go & ~pick_dec;
  assign gnt_dec  = arb_go & pick_dec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      rr_ptr <= 1'b0;
      job_id <= ID_ENC;
      cnt    <= 4'd0;
    end else begin
      state <= state_nxt;
      if (arb_go) begin
        job_id <= pick_dec ? ID_DEC : ID_ENC;
        if (req_enc && req_dec) begin
          rr_ptr <= ~rr_ptr;
        end
      end
      if (state == ST_GRANT) begin
        cnt <= 4'(PREPASS_CYC - 1);
      end else if (state == ST_LOAD) begin
        cnt <= 4'(NR - 2);
      end else if ((state == ST_PREPASS || state == ST_ROUND) && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

`ifdef AES_ROUND_SCHED_KEYCACHE_EN
  logic cache_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_valid <= 1'b0;
      skip_pre    <= 1'b0;
    end else begin
      if (gnt_enc) begin
        cache_valid <= 1'b0;
      end else if (state == ST_DONE && job_dec) begin
        cache_valid <= 1'b1;
      end
      if (arb_go) begin
        skip_pre <= gnt_dec & key_same & cache_valid;
      end
    end
  end
`else
  assign skip_pre = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    rc_ld_first = 1'b0;
    rc_ld_last  = 1'b0;
    rc_fwd      = 1'b0;
    rc_inv      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_go) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (!job_dec) begin
          state_nxt   = ST_LOAD;
          rc_ld_first = 1'b1;
        end else if (skip_pre) begin
          state_nxt  = ST_LOAD;
          rc_ld_last = 1'b1;
        end else begin
          state_nxt   = ST_PREPASS;
          rc_ld_first = 1'b1;
        end
      end
      ST_PREPASS: begin
        // Park on 0x36 rather than stepping past it: LOAD and DEC round 1 need it.
        if (cnt == 4'd0) begin
          state_nxt  = ST_LOAD;
          rc_ld_last = 1'b1;
        end else begin
          rc_fwd = 1'b1;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        rc_fwd = ~job_dec;
        rc_inv = job_dec;
        if (cnt == 4'd0) state_nxt = ST_FINAL;
      end
      ST_FINAL: begin
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    round_idx = 4'd0;
    case (state)
      ST_PREPASS: round_idx = 4'(PREPASS_CYC) - cnt;
      ST_ROUND:   round_idx = 4'(NR - 1) - cnt;
      ST_FINAL:   round_idx = 4'(NR);
      default:    round_idx = 4'd0;
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign dp_mode    = busy & job_dec;
  assign dp_load    = (state == ST_LOAD);
  assign dp_round   = (state == ST_ROUND) | (state == ST_FINAL);
  assign dp_last    = (state == ST_FINAL);
  assign key_step   = (state == ST_PREPASS) | dp_round;
  assign key_dir    = job_dec & (dp_load | dp_round);
  assign done       = (state == ST_DONE);
  assign done_id    = done & job_dec;
  assign test_state = state;

  aes_rcon_gen u_rcon (
    .clk      (clk),
    .reset    (reset),
    .ld_first (rc_ld_first),
    .ld_last  (rc_ld_last),
    .step_fwd (rc_fwd),
    .step_inv (rc_inv),
    .rcon     (rcon)
  );

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched: per-cycle timeline model plus directed
// literal checks; exercises the key cache when AES_ROUND_SCHED_KEYCACHE_EN is defined.
module tb_aes_round_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_enc = 1'b0;
  logic       req_dec = 1'b0;
`ifdef AES_ROUND_SCHED_KEYCACHE_EN
  logic       key_same = 1'b0;
`endif
  logic       gnt_enc, gnt_dec, busy, dp_mode, dp_load, dp_round, dp_last;
  logic       key_step, key_dir, done, done_id;
  logic [7:0] rcon;
  logic [3:0] round_idx;
  logic [4:0] test_state;

  aes_round_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req_enc    (req_enc),
    .req_dec    (req_dec),
`ifdef AES_ROUND_SCHED_KEYCACHE_EN
    .key_same   (key_same),
`endif
    .gnt_enc    (gnt_enc),
    .gnt_dec    (gnt_dec),
    .busy       (busy),
    .dp_mode    (dp_mode),
    .dp_load    (dp_load),
    .dp_round   (dp_round),
    .dp_last    (dp_last),
    .key_step   (key_step),
    .key_dir    (key_dir),
    .rcon       (rcon),
    .round_idx  (round_idx),
    .done       (done),
    .done_id    (done_id),
    .test_state (test_state)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] RC_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  typedef struct packed {
    logic       busy, mode, load, rnd, last, kstep, kdir, dn, did;
    logic [7:0] rcon;
    logic [3:0] idx;
    logic [4:0] ts;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q[$];
  bit   m_ptr = 1'b0;
  bit   m_cache = 1'b0;
  bit   m_gnt_enc = 1'b0;
  bit   m_gnt_dec = 1'b0;
  bit   auto_drop = 1'b1;

  // Observations used by the directed checks.
  int   g_cyc, d_cyc, load_cyc, last_cyc, ndone;
  logic [7:0] load_rcon, last_rcon;
  logic last_mode;
  logic g_q[$];
  logic d_q[$];
  logic [7:0] rc_seq[$];
  logic [7:0] pre_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Full job timeline from the grant-following cycle through done.
  function automatic void push_job(input bit dec, input bit skip);
    exp_t e;
    e = '0; e.busy = 1; e.mode = dec; e.ts = 5'd1;
    q.push_back(e);
    if (dec && !skip) begin
      for (int i = 1; i <= 10; i++) begin
        e = '0; e.busy = 1; e.mode = 1; e.kstep = 1;
        e.rcon = RC_TAB[i-1]; e.idx = 4'(i); e.ts = 5'd2;
        q.push_back(e);
      end
    end
    e = '0; e.busy = 1; e.mode = dec; e.load = 1; e.kdir = dec;
    e.rcon = dec ? 8'h36 : 8'h01; e.ts = 5'd3;
    q.push_back(e);
    for (int i = 1; i <= 9; i++) begin
      e = '0; e.busy = 1; e.mode = dec; e.rnd = 1; e.kstep = 1; e.kdir = dec;
      e.idx = 4'(i); e.rcon = dec ? RC_TAB[10-i] : RC_TAB[i-1]; e.ts = 5'd4;
      q.push_back(e);
    end
    e = '0; e.busy = 1; e.mode = dec; e.rnd = 1; e.last = 1; e.kstep = 1; e.kdir = dec;
    e.idx = 4'd10; e.rcon = dec ? 8'h01 : 8'h36; e.ts = 5'd5;
    q.push_back(e);
    e = '0; e.busy = 1; e.mode = dec; e.dn = 1; e.did = dec; e.ts = 5'd6;
    q.push_back(e);
  endfunction

  task automatic check_all(input exp_t e, input bit ge, input bit gd, input bit rst);
    chk("gnt_enc", 32'(gnt_enc), 32'(ge));
    chk("gnt_dec", 32'(gnt_dec), 32'(gd));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("dp_load", 32'(dp_load), 32'(e.load));
    chk("dp_round", 32'(dp_round), 32'(e.rnd));
    chk("dp_last", 32'(dp_last), 32'(e.last));
    chk("key_step", 32'(key_step), 32'(e.kstep));
    chk("done", 32'(done), 32'(e.dn));
    chk("test_state", 32'(test_state), 32'(e.ts));
    if (e.busy || rst) chk("dp_mode", 32'(dp_mode), 32'(e.mode));
    if (e.kstep || e.load || rst) begin
      chk("key_dir", 32'(key_dir), 32'(e.kdir));
      chk("rcon", 32'(rcon), 32'(e.rcon));
    end
    if (e.kstep || e.load || !e.busy) chk("round_idx", 32'(round_idx), 32'(e.idx));
    if (e.dn || rst) chk("done_id", 32'(done_id), 32'(e.did));
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    bit   dec, skip;
    m_gnt_enc = 0;
    m_gnt_dec = 0;
    if (!reset) begin
      q.delete();
      m_ptr = 0;
      m_cache = 0;
      e = '0;
      e.rcon = 8'h01;
      check_all(e, 0, 0, 1);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      check_all(e, 0, 0, 0);
      if (e.dn && e.did) m_cache = 1;
    end else begin
      e = '0;
      if (req_enc || req_dec) begin
        dec = req_dec && (!req_enc || m_ptr);
        if (req_enc && req_dec) m_ptr = !m_ptr;
        skip = 0;
`ifdef AES_ROUND_SCHED_KEYCACHE_EN
        skip = dec && key_same && m_cache;
`endif
        if (!dec) m_cache = 0;
        m_gnt_enc = !dec;
        m_gnt_dec = dec;
        push_job(dec, skip);
      end
      check_all(e, m_gnt_enc, m_gnt_dec, 0);
    end
    if (gnt_enc || gnt_dec) begin g_cyc = cyc; g_q.push_back(gnt_dec); end
    if (done) begin d_cyc = cyc; d_q.push_back(done_id); ndone++; end
    if (dp_load) begin load_cyc = cyc; load_rcon = rcon; end
    if (dp_last) begin last_cyc = cyc; last_rcon = rcon; last_mode = dp_mode; end
    if (dp_round) rc_seq.push_back(rcon);
    if (key_step && !dp_round && !key_dir) pre_q.push_back(rcon);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) begin
      if (m_gnt_enc) req_enc = 0;
      if (m_gnt_dec) req_dec = 0;
    end
  endtask

  task automatic wait_done(input int limit);
    int  n0;
    bit  ok;
    n0 = ndone;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (ndone > n0) ok = 1;
    end
    chk("done_within_bound", 32'(ok), 32'd1);
  endtask

`ifdef AES_ROUND_SCHED_KEYCACHE_EN
  task automatic run_job(input bit dec, input bit ks, input int exp_lat, input string name);
    key_same = ks;
    if (dec) req_dec = 1; else req_enc = 1;
    wait_done(40);
    chk(name, 32'(d_cyc - g_cyc - 1), 32'(exp_lat));
    tick();
  endtask
`endif

  initial begin : main
    int t0, n0;
    bit ok;
    g_cyc = 0; d_cyc = 0; load_cyc = 0; last_cyc = 0; ndone = 0;
    repeat (3) tick();
    reset = 1;
    repeat (4) tick();

    // ENC alone: grant, LOAD +2, FINAL +12, DONE +13
    rc_seq.delete();
    t0 = cyc;
    req_enc = 1;
    wait_done(40);
    chk("enc_gnt_cycle", 32'(g_cyc - t0), 32'd0);
    chk("enc_load_cycle", 32'(load_cyc - t0), 32'd2);
    chk("enc_last_cycle", 32'(last_cyc - t0), 32'd12);
    chk("enc_done_cycle", 32'(d_cyc - t0), 32'd13);
    chk("enc_done_id", 32'(d_q[$]), 32'd0);
    chk("enc_rcon_count", 32'(rc_seq.size()), 32'd10);
    if (rc_seq.size() == 10)
      for (int i = 0; i < 10; i++) chk("enc_rcon_seq", 32'(rc_seq[i]), 32'(RC_TAB[i]));
    repeat (3) tick();

    // DEC alone: pre-pass, inverse rounds, 22 busy cycles ahead of done
    pre_q.delete();
    req_dec = 1;
    wait_done(60);
    chk("dec_prepass_count", 32'(pre_q.size()), 32'd10);
    if (pre_q.size() == 10)
      for (int i = 0; i < 10; i++) chk("dec_prepass_rcon", 32'(pre_q[i]), 32'(RC_TAB[i]));
    chk("dec_load_rcon", 32'(load_rcon), 32'h36);
    chk("dec_final_rcon", 32'(last_rcon), 32'h01);
    chk("dec_final_mode", 32'(last_mode), 32'd1);
    chk("dec_latency", 32'(d_cyc - g_cyc - 1), 32'd22);
    chk("dec_done_id", 32'(d_q[$]), 32'd1);
    repeat (3) tick();

    // Both held continuously: ENC, DEC, ENC
    g_q.delete();
    d_q.delete();
    auto_drop = 0;
    req_enc = 1;
    req_dec = 1;
    ok = 0;
    for (int i = 0; i < 120 && !ok; i++) begin
      tick();
      if (g_q.size() >= 3) ok = 1;
    end
    chk("rr_three_grants", 32'(ok), 32'd1);
    req_enc = 0;
    req_dec = 0;
    auto_drop = 1;
    wait_done(40);
    if (g_q.size() >= 3 && d_q.size() >= 3) begin
      chk("rr_gnt0", 32'(g_q[0]), 32'd0);
      chk("rr_gnt1", 32'(g_q[1]), 32'd1);
      chk("rr_gnt2", 32'(g_q[2]), 32'd0);
      chk("rr_done0", 32'(d_q[0]), 32'd0);
      chk("rr_done1", 32'(d_q[1]), 32'd1);
      chk("rr_done2", 32'(d_q[2]), 32'd0);
    end else begin
      chk("rr_done_count", 32'(d_q.size()), 32'd3);
    end
    repeat (3) tick();

    // Reset at round 4 of an ENC job, DEC waiting across the reset
    req_enc = 1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (dp_round && round_idx == 4'd4) ok = 1;
    end
    chk("reach_round4", 32'(ok), 32'd1);
    n0 = ndone;
    reset = 0;
    req_dec = 1;
    #1;
    chk("rst_state", 32'(test_state), 32'd0);
    chk("rst_rcon", 32'(rcon), 32'h01);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_round", 32'(dp_round), 32'd0);
    repeat (2) tick();
    reset = 1;
    wait_done(60);
    chk("rst_single_done", 32'(ndone - n0), 32'd1);
    chk("rst_regrant_dec", 32'(d_q[$]), 32'd1);
    repeat (3) tick();

    // Random traffic, including requests withdrawn before grant
    for (int i = 0; i < 600; i++) begin
      tick();
      if (!req_enc && $urandom_range(3) == 0) req_enc = 1;
      else if (req_enc && $urandom_range(31) == 0) req_enc = 0;
      if (!req_dec && $urandom_range(3) == 0) req_dec = 1;
      else if (req_dec && $urandom_range(31) == 0) req_dec = 0;
`ifdef AES_ROUND_SCHED_KEYCACHE_EN
      key_same = 1'($urandom_range(1));
`endif
    end
    req_enc = 0;
    req_dec = 0;
    repeat (30) tick();

`ifdef AES_ROUND_SCHED_KEYCACHE_EN
    reset = 0;
    repeat (2) tick();
    reset = 1;
    tick();
    run_job(1, 0, 22, "kc_dec_miss");
    run_job(1, 1, 12, "kc_dec_hit");
    run_job(0, 1, 12, "kc_enc");
    run_job(1, 1, 22, "kc_dec_after_enc");
    repeat (3) tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_round_sched.md
Name: aes_round_sched

Overview:
- Controller that sequences one shared AES-128 round datapath (forward and inverse round logic plus a round-key register) between two requesters: encrypt (ENC) and decrypt (DEC).
- Arbitrates requests and issues per-cycle round strobes, round index and rcon to the datapath.
- Before any DEC job, runs a forward key-expansion pre-pass to reach round key 10.
- Signals completion with a one-cycle done pulse and the winning requester ID.

Parameters:
- NR, 10, number of AES rounds; round_idx width is 4.
- PREPASS_CYC, 10, cycles in the DEC forward key-expansion pre-pass.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_enc  in  1  ENC request; held until gnt_enc
- req_dec  in  1  DEC request; held until gnt_dec
- gnt_enc  out  1  one-cycle grant; datapath latches ENC data_in/key_in this cycle
- gnt_dec  out  1  one-cycle grant for DEC
- busy  out  1  high from grant through done
- dp_mode  out  1  0 = forward round, 1 = inverse round; valid while busy
- dp_load  out  1  load data register with data_in XOR key (initial AddRoundKey)
- dp_round  out  1  perform one round this cycle
- dp_last  out  1  final round (no MixColumns or InvMixColumns); coincident with dp_round
- key_step  out  1  advance round key (forward or inverse per key_dir)
- key_dir  out  1  0 = forward expansion, 1 = inverse expansion
- rcon  out  8  round constant for the current key step
- round_idx  out  4  current round, 0..NR
- done  out  1  one-cycle pulse; datapath output valid this cycle
- done_id  out  1  0 = ENC, 1 = DEC; valid when done
- test_state  out  5  encoded FSM state for debug

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, except rcon = 8'h01.
  - Round-robin pointer is set to ENC priority.
- FSM states and test_state encoding: IDLE = 0, GRANT = 1, PREPASS = 2, LOAD = 3, ROUND = 4, FINAL = 5, DONE = 6.
- IDLE:
  - With only one request pending, grant it.
  - With both pending, grant the side the pointer favours. The pointer then flips to the other side.
  - The grant is asserted combinationally in the cycle IDLE goes to GRANT.
- GRANT (1 cycle):
  - ENC goes to LOAD.
  - DEC goes to PREPASS.
- PREPASS (DEC only):
  - Runs PREPASS_CYC cycles with key_step = 1 and key_dir = 0.
  - rcon runs 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - round_idx counts 1..10.
  - Then goes to LOAD.
- LOAD (1 cycle):
  - dp_load = 1 and round_idx = 0.
  - For ENC, rcon is reset to 01.
  - For DEC, rcon is 36 and key_dir = 1.
- ROUND:
  - NR-1 cycles with dp_round = 1 and key_step = 1.
  - ENC: round_idx runs 1..9 and rcon advances forward (xtime, with 80 wrapping to 1B).
  - DEC: round_idx runs 1..9 and rcon steps backward (36, 1B, 80 ... 02).
  - Then goes to FINAL.
- FINAL (1 cycle):
  - dp_round = 1, dp_last = 1, key_step = 1, round_idx = NR.
  - DEC uses rcon = 01.
- DONE (1 cycle): done = 1 and done_id valid, then returns to IDLE.
- Fixed latency, grant to done:
  - ENC: 1 + 1 + 9 + 1 = 12 cycles.
  - DEC: 22 cycles.
- busy is high from GRANT through DONE inclusive.
- Requests arriving while busy are ignored until IDLE. A request dropped before its grant is simply not serviced; no error is raised.
- Simultaneous done and a new request: no grant in the DONE cycle; arbitration happens in IDLE on the next cycle.
- Reset mid-job: abort immediately to the reset values. No done is issued, and the pointer returns to ENC priority.
- round_idx never exceeds NR; rcon is held when key_step = 0.

Optional Feature:
- Macro: AES_ROUND_SCHED_KEYCACHE_EN.
- When defined:
  - Adds input key_same (1-bit, sampled at grant): the datapath asserts it when key_in equals the last expanded key.
  - If key_same = 1 and the previous completed DEC used that key, DEC skips PREPASS and goes GRANT to LOAD, giving 12-cycle latency.
  - The cache-valid flag clears on reset or on any ENC job.
- When undefined: there is no key_same port and DEC always runs PREPASS.

Decomposition:
- Package aes_sched_pkg holds:
  - the state encoding constants (IDLE..DONE, 5-bit);
  - NR;
  - RCON_FIRST = 8'h01 and RCON_LAST = 8'h36;
  - the ENC/DEC ID constants.
- One sub-module, aes_rcon_gen: an 8-bit rcon register with fwd/inv step, load-01 and load-36 controls. Forward step is xtime; inverse step is the inverse of xtime.
- Arbiter and counter logic stay in the top module.

Test Plan:
- ENC only, req_enc held from cycle 5:
  - gnt_enc at cycle 5, dp_load at 7.
  - dp_round with round_idx 1..9 at 8..16; dp_last with round_idx 10 at 17.
  - done at 18 with done_id = 0.
  - rcon sequence 01..36.
- DEC only:
  - PREPASS shows key_step = 1, key_dir = 0 for 10 cycles with rcon 01..36.
  - LOAD shows rcon = 36.
  - FINAL shows rcon = 01 and dp_mode = 1.
  - done 22 cycles after the grant.
- Both requests held continuously: grants alternate ENC, DEC, ENC, with done_id sequence 0, 1, 0 and no grant while busy.
- reset pulled low at ROUND round_idx = 4:
  - All outputs are 0 within the same cycle, with rcon = 01 and test_state = 0.
  - No done is issued; after reset releases, a pending request is regranted.
- AES_ROUND_SCHED_KEYCACHE_EN defined: DEC (key_same = 0), then DEC (key_same = 1), then ENC, then DEC (key_same = 1) gives latencies 22, 12, 12, 22.
